// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared types and constants for the instruction-memory boot
//               loader. Holds the loader FSM state encoding, the default
//               memory depth, the instruction width and the terminator word.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    localparam int          IMEM_DEPTH = 32;
    localparam int          INSTR_W    = 32;
    localparam logic [31:0] TERMINATOR = 32'd0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_e;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : 8-to-32 bit MSB-first shift register with a 2-bit byte count.
//               The first pushed byte ends up in [31:24], the fourth in [7:0].
//               The count wraps 3 -> 0, so a new word starts automatically.
// Ports       : clk_i   - clock (rising edge)
//               rst_i   - synchronous active-high reset
//               clr_i   - discard the partial word and zero the count
//               push_i  - shift data_i in this cycle
//               data_i  - byte to shift in
//               word_o  - assembled word (registered)
//               full_o  - three bytes held: the next push completes a word
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import imem_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               push_i,
    input  logic [7:0]         data_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               full_o
);

    logic [INSTR_W-1:0] word_q, word_d;
    logic [1:0]         cnt_q,  cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            word_d = '0;
            cnt_d  = 2'd0;
        end else if (push_i) begin
            word_d = {word_q[INSTR_W-9:0], data_i};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o = word_q;
    assign full_o = (cnt_q == 2'd3);

endmodule : byte_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time writer for the CPU instruction memory. Packs a
//               valid/ready byte stream MSB-first into 32-bit words, writes
//               them to consecutive word addresses and holds the CPU in reset
//               until an all-zero terminator word has been stored. Filling
//               the whole memory without a terminator ends in an error state.
// Ports       : clk_i, rst_i        - clock, synchronous active-high reset
//               start_i             - one-cycle pulse starting a load
//               byte_valid_i/_data_i/byte_ready_o - byte stream handshake
//               mem_we_o/_addr_o/_wdata_o         - imem write port
//               cpu_rst_n_o         - active-low CPU reset (high once done)
//               done_o, err_o       - load status
//               word_count_o        - words written incl. terminator
//               checksum_o          - XOR of written words
// Options     : IMEM_LOADER_CHECKSUM_EN - builds the checksum accumulator;
//               when undefined checksum_o is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               byte_valid_i,
    input  logic [7:0]         byte_data_i,
    output logic               byte_ready_o,
    output logic               mem_we_o,
    output logic [AW-1:0]      mem_addr_o,
    output logic [INSTR_W-1:0] mem_wdata_o,
    output logic               cpu_rst_n_o,
    output logic               done_o,
    output logic               err_o,
    output logic [AW:0]        word_count_o,
    output logic [INSTR_W-1:0] checksum_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [AW:0]        word_count_q, word_count_d;
    logic               byte_ready_q, byte_ready_d;
    logic               mem_we_q, mem_we_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               cpu_rst_n_q, cpu_rst_n_d;

    logic               load_start;
    logic               push;
    logic               pack_full;
    logic [INSTR_W-1:0] pack_word;

    // A load may only be (re)started from a resting state; start_i is
    // ignored while bytes are being collected or a word is being written.
    assign load_start = start_i && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign push       = byte_valid_i && byte_ready_q;

    byte_packer u_packer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (load_start),
        .push_i (push),
        .data_i (byte_data_i),
        .word_o (pack_word),
        .full_o (pack_full)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (load_start) begin
                    state_d      = RECV;
                    addr_d       = '0;
                    word_count_d = '0;
                end
            end
            RECV: begin
                if (push && pack_full) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                word_count_d = word_count_q + (AW+1)'(1);
                if (pack_word == TERMINATOR) begin
                    state_d = DONE;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = ERR;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = RECV;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are decoded from the next state so they are
        // registered and line up with the state they describe.
        byte_ready_d = (state_d == RECV);
        mem_we_d     = (state_d == WRITE);
        done_d       = (state_d == DONE);
        err_d        = (state_d == ERR);
        cpu_rst_n_d  = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            word_count_q <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0] checksum_q, checksum_d;

    // Folds in the word on the edge that closes its write cycle, the same
    // edge that bumps word_count.
    always_comb begin
        checksum_d = checksum_q;
        if (load_start) begin
            checksum_d = '0;
        end else if (state_q == WRITE) begin
            checksum_d = checksum_q ^ pack_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = '0;
`endif

    assign byte_ready_o = byte_ready_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = pack_word;
    assign cpu_rst_n_o  = cpu_rst_n_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign word_count_o = word_count_q;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Table of whole loads
//               (words in, expected status out) plus hand-written sequences
//               for reset, reset mid-word and start_i during a load. Expected
//               memory writes are queued when words are sent and compared
//               when the DUT strobes mem_we_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;
    import imem_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          bvalid;
    logic [7:0]    bdata;
    logic          byte_ready_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          cpu_rst_n_o;
    logic          done_o;
    logic          err_o;
    logic [AW:0]   word_count_o;
    logic [31:0]   checksum_o;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .byte_valid_i (bvalid),
        .byte_data_i  (bdata),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .cpu_rst_n_o  (cpu_rst_n_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .word_count_o (word_count_o),
        .checksum_o   (checksum_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard of expected memory writes ----------------
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t  exp_q[$];
    logic prev_we = 1'b0;

    always @(negedge clk) begin
        wr_t e;
        if (mem_we_o === 1'b1) begin
            chk("we_single_cycle", {63'd0, prev_we}, 64'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: addr %0h data %h, expected no write",
                         mem_addr_o, mem_wdata_o);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {59'd0, mem_addr_o}, {59'd0, e.addr});
                chk("wr_data", {32'd0, mem_wdata_o}, {32'd0, e.data});
            end
        end
        prev_we = (mem_we_o === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the handshake.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t = 0;
        if (gaps && $urandom_range(1, 0) == 1) begin
            bvalid = 1'b0;
            repeat ($urandom_range(3, 1)) tick();
        end
        bvalid = 1'b1;
        bdata  = b;
        @(negedge clk);
        while (byte_ready_o !== 1'b1 && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (t >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL byte_handshake: byte %h never accepted, expected acceptance", b);
        end
        tick();
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps, input logic [AW-1:0] addr);
        exp_q.push_back({addr, w});
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8], gaps);
        end
    endtask

    task automatic wait_end;
        int t = 0;
        @(negedge clk);
        while (!(done_o === 1'b1 || err_o === 1'b1) && t < 40) begin
            t++;
            @(negedge clk);
        end
        if (t >= 40) begin
            n_vec++;
            n_err++;
            $display("FAIL end_timeout: done/err never rose, expected one of them");
        end
    endtask

    // ---------------- table of whole loads ----------------
    typedef struct {
        string       name;
        int          n;
        logic [31:0] w [DEPTH];
        bit          gaps;
        logic        exp_done;
        logic        exp_err;
        int          exp_cnt;
        logic [31:0] exp_csum;
    } load_t;

    load_t tbl[5];

    task automatic run_load(input int idx);
        // start sampled at edge N: ready high in cycle N+1, status cleared
        do_start();
        @(negedge clk);
        chk({tbl[idx].name, "_start_ready"}, {63'd0, byte_ready_o}, 64'd1);
        chk({tbl[idx].name, "_start_done"}, {63'd0, done_o}, 64'd0);
        chk({tbl[idx].name, "_start_cpurst"}, {63'd0, cpu_rst_n_o}, 64'd0);
        chk({tbl[idx].name, "_start_count"}, {58'd0, word_count_o}, 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < tbl[idx].n; i++) begin
            send_word(tbl[idx].w[i], tbl[idx].gaps, AW'(i));
        end
        bvalid = 1'b0;
        wait_end();
        chk({tbl[idx].name, "_done"}, {63'd0, done_o}, {63'd0, tbl[idx].exp_done});
        chk({tbl[idx].name, "_err"}, {63'd0, err_o}, {63'd0, tbl[idx].exp_err});
        chk({tbl[idx].name, "_cpurst"}, {63'd0, cpu_rst_n_o}, {63'd0, tbl[idx].exp_done});
        chk({tbl[idx].name, "_count"}, {58'd0, word_count_o}, 64'(tbl[idx].exp_cnt));
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk({tbl[idx].name, "_csum"}, {32'd0, checksum_o}, {32'd0, tbl[idx].exp_csum});
`else
        chk({tbl[idx].name, "_csum"}, {32'd0, checksum_o}, 64'd0);
`endif
        chk({tbl[idx].name, "_all_writes_seen"}, 64'(exp_q.size()), 64'd0);
        chk({tbl[idx].name, "_ready_low"}, {63'd0, byte_ready_o}, 64'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        bvalid = 1'b0;
        bdata  = 8'h00;

        tbl[0].name = "basic";
        tbl[0].n = 3;  tbl[0].gaps = 1'b0;
        tbl[0].w[0] = 32'h20010005; tbl[0].w[1] = 32'h00211013; tbl[0].w[2] = 32'h0;
        tbl[0].exp_done = 1'b1; tbl[0].exp_err = 1'b0; tbl[0].exp_cnt = 3;
        tbl[0].exp_csum = 32'h20201016;

        tbl[1] = tbl[0];
        tbl[1].name = "backpressure";
        tbl[1].gaps = 1'b1;

        tbl[2].name = "checksum";
        tbl[2].n = 3;  tbl[2].gaps = 1'b0;
        tbl[2].w[0] = 32'h12345678; tbl[2].w[1] = 32'h0F0F0F0F; tbl[2].w[2] = 32'h0;
        tbl[2].exp_done = 1'b1; tbl[2].exp_err = 1'b0; tbl[2].exp_cnt = 3;
        tbl[2].exp_csum = 32'h1D3B5977;

        tbl[3].name = "overflow";
        tbl[3].n = DEPTH; tbl[3].gaps = 1'b0;
        for (int i = 0; i < DEPTH; i++) tbl[3].w[i] = 32'h20010001;
        tbl[3].exp_done = 1'b0; tbl[3].exp_err = 1'b1; tbl[3].exp_cnt = DEPTH;
        tbl[3].exp_csum = 32'h0;

        tbl[4].name = "term_only";
        tbl[4].n = 1;  tbl[4].gaps = 1'b0;
        tbl[4].w[0] = 32'h0;
        tbl[4].exp_done = 1'b1; tbl[4].exp_err = 1'b0; tbl[4].exp_cnt = 1;
        tbl[4].exp_csum = 32'h0;

        // ---- reset values, reset held for two cycles ----
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {63'd0, byte_ready_o}, 64'd0);
        chk("rst_we", {63'd0, mem_we_o}, 64'd0);
        chk("rst_addr", {59'd0, mem_addr_o}, 64'd0);
        chk("rst_wdata", {32'd0, mem_wdata_o}, 64'd0);
        chk("rst_cpurst", {63'd0, cpu_rst_n_o}, 64'd0);
        chk("rst_done", {63'd0, done_o}, 64'd0);
        chk("rst_err", {63'd0, err_o}, 64'd0);
        chk("rst_count", {58'd0, word_count_o}, 64'd0);
        chk("rst_csum", {32'd0, checksum_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // ---- reset in the middle of a word: no write, back to IDLE ----
        do_start();
        send_byte(8'h20, 1'b0);
        send_byte(8'h01, 1'b0);
        bvalid = 1'b0;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {63'd0, byte_ready_o}, 64'd0);
        chk("midrst_wdata", {32'd0, mem_wdata_o}, 64'd0);
        chk("midrst_count", {58'd0, word_count_o}, 64'd0);
        chk("midrst_done", {63'd0, done_o}, 64'd0);
        repeat (4) @(negedge clk);
        chk("midrst_idle_ready", {63'd0, byte_ready_o}, 64'd0);
        @(posedge clk);
        #1;
        run_load(4);

        // ---- table of complete loads ----
        for (int k = 0; k < 5; k++) begin
            run_load(k);
        end

        // ---- start_i during RECV must not disturb the word in progress ----
        do_start();
        exp_q.push_back({AW'(0), 32'h12345678});
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        bvalid = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b0);
        send_word(32'h0, 1'b0, AW'(1));
        bvalid = 1'b0;
        wait_end();
        chk("startign_done", {63'd0, done_o}, 64'd1);
        chk("startign_count", {58'd0, word_count_o}, 64'd2);
        chk("startign_writes_seen", 64'(exp_q.size()), 64'd0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
